// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared fp16 constants, field positions, NaN test and scanner FSM states
//
// Purpose: common definitions for the fp16 min/max scanner and its comparator.
// Contents: FP16_QNAN, field bit positions, is_nan(), state_e {IDLE, ACCUM, DONE}.
package fp16_pkg;

  localparam logic [15:0] FP16_QNAN     = 16'h7E00;
  localparam int          FP16_SIGN     = 15;
  localparam int          FP16_EXP_MSB  = 14;
  localparam int          FP16_EXP_LSB  = 10;
  localparam int          FP16_MANT_MSB = 9;
  localparam int          FP16_MANT_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  function automatic logic is_nan(input logic [15:0] x);
    return (x[FP16_EXP_MSB:FP16_EXP_LSB] == 5'h1F) &&
           (x[FP16_MANT_MSB:FP16_MANT_LSB] != 10'd0);
  endfunction

endpackage

// File: rtl/fp16_lt.sv
// rtl/fp16_lt.sv - combinational fp16 strict less-than in sign-magnitude total order
//
// Purpose: lt_o = a_i < b_i, with -inf lowest, +inf highest, +0 == -0,
//          subnormals ordered by magnitude. Inputs are assumed non-NaN.
// Ports:
//   a_i  in  16  left operand
//   b_i  in  16  right operand
//   lt_o out 1   a_i strictly below b_i
module fp16_lt
  import fp16_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        lt_o
);

  // Map each value onto an unsigned key whose integer order is the float
  // order: positives sit above 16'h8000, negatives are bit-inverted so a
  // larger magnitude yields a smaller key, and both zeros share one key.
  function automatic logic [15:0] order_key(input logic [15:0] x);
    if (x[FP16_EXP_MSB:FP16_MANT_LSB] == 15'd0) begin
      return 16'h8000;
    end else if (x[FP16_SIGN]) begin
      return ~x;
    end else begin
      return {1'b1, x[FP16_EXP_MSB:FP16_MANT_LSB]};
    end
  endfunction

  assign lt_o = order_key(a_i) < order_key(b_i);

endmodule

// File: rtl/fp16_minmax_scan.sv
// rtl/fp16_minmax_scan.sv - streaming fp16 running min/max scanner with per-burst summary
//
// Purpose: accepts a burst of fp16 elements, tracks min/max (with index),
//          element count, NaN status and overflow, and presents one
//          registered summary per burst.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_data/in_valid/in_last        element stream input
//   in_ready                        registered accept flag
//   out_valid/out_ready             summary handshake
//   out_min/out_max                 min/max non-NaN element (QNAN if none)
//   out_min_idx/out_max_idx         burst positions of min/max
//   out_count                       saturating element count
//   out_nan_seen/out_all_nan        NaN status
//   out_ovf                         burst longer than 2^IDX_W-1
module fp16_minmax_scan
  import fp16_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_min,
  output logic [15:0]      out_max,
  output logic [IDX_W-1:0] out_min_idx,
  output logic [IDX_W-1:0] out_max_idx,
  output logic [IDX_W-1:0] out_count,
  output logic             out_nan_seen,
  output logic             out_all_nan,
  output logic             out_ovf
);

  state_e           state_q;
  logic             in_ready_q, out_valid_q;

  // Running accumulators for the burst in progress.
  logic [15:0]      min_q, max_q;
  logic [IDX_W-1:0] min_idx_q, max_idx_q, count_q;
  logic             nan_q, num_q, ovf_q;

  // Registered summary.
  logic [15:0]      out_min_q, out_max_q;
  logic [IDX_W-1:0] out_min_idx_q, out_max_idx_q, out_count_q;
  logic             out_nan_q, out_all_nan_q, out_ovf_q;

  // Accumulator values after absorbing the current element.
  logic [15:0]      min_d, max_d;
  logic [IDX_W-1:0] min_idx_d, max_idx_d, count_d;
  logic             nan_d, num_d, ovf_d;

  logic             accept, fresh, cand_nan, cand_lt_min, cand_gt_max, sat;
  logic             take_min, take_max;
  logic [IDX_W-1:0] base_count;
  logic             base_num, base_nan, base_ovf;

  fp16_lt u_lt_min (.a_i(in_data), .b_i(min_q),   .lt_o(cand_lt_min));
  fp16_lt u_gt_max (.a_i(max_q),   .b_i(in_data), .lt_o(cand_gt_max));

  always_comb begin
    accept     = in_valid && in_ready_q;
    // An element taken in IDLE starts a new burst, so stale accumulators
    // from the previous burst are ignored rather than cleared.
    fresh      = (state_q == IDLE);
    base_count = fresh ? '0 : count_q;
    base_num   = fresh ? 1'b0 : num_q;
    base_nan   = fresh ? 1'b0 : nan_q;
    base_ovf   = fresh ? 1'b0 : ovf_q;
    sat        = &base_count;
    cand_nan   = is_nan(in_data);

    // Strict compares keep the earliest index on ties; the first non-NaN
    // element loads both unconditionally.
    take_min   = !cand_nan && (!base_num || cand_lt_min);
    take_max   = !cand_nan && (!base_num || cand_gt_max);

    min_d      = take_min ? in_data    : min_q;
    min_idx_d  = take_min ? base_count : min_idx_q;
    max_d      = take_max ? in_data    : max_q;
    max_idx_d  = take_max ? base_count : max_idx_q;
    count_d    = sat ? base_count : base_count + {{(IDX_W-1){1'b0}}, 1'b1};
    nan_d      = base_nan | cand_nan;
    num_d      = base_num | !cand_nan;
    ovf_d      = base_ovf | sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      min_q         <= '0;
      max_q         <= '0;
      min_idx_q     <= '0;
      max_idx_q     <= '0;
      count_q       <= '0;
      nan_q         <= 1'b0;
      num_q         <= 1'b0;
      ovf_q         <= 1'b0;
      out_min_q     <= '0;
      out_max_q     <= '0;
      out_min_idx_q <= '0;
      out_max_idx_q <= '0;
      out_count_q   <= '0;
      out_nan_q     <= 1'b0;
      out_all_nan_q <= 1'b0;
      out_ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          // Also brings in_ready up on the first edge out of reset.
          in_ready_q <= !(accept && in_last);
          if (accept) begin
            min_q     <= min_d;
            max_q     <= max_d;
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
            count_q   <= count_d;
            nan_q     <= nan_d;
            num_q     <= num_d;
            ovf_q     <= ovf_d;
            if (in_last) begin
              state_q       <= DONE;
              out_valid_q   <= 1'b1;
              out_min_q     <= num_d ? min_d : FP16_QNAN;
              out_max_q     <= num_d ? max_d : FP16_QNAN;
              out_min_idx_q <= num_d ? min_idx_d : '0;
              out_max_idx_q <= num_d ? max_idx_d : '0;
              out_count_q   <= count_d;
              out_nan_q     <= nan_d;
              out_all_nan_q <= !num_d;
              out_ovf_q     <= ovf_d;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_min      = out_min_q;
  assign out_max      = out_max_q;
  assign out_min_idx  = out_min_idx_q;
  assign out_max_idx  = out_max_idx_q;
  assign out_count    = out_count_q;
  assign out_nan_seen = out_nan_q;
  assign out_all_nan  = out_all_nan_q;
  assign out_ovf      = out_ovf_q;

endmodule

// File: tb/tb_fp16_minmax_scan.sv
// tb/tb_fp16_minmax_scan.sv - scoreboard bench for fp16_minmax_scan at IDX_W 8 and 2
module tb_fp16_minmax_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready;
  int          rdy_mode = 0;

  logic        r8, v8, nan8, alln8, ovf8;
  logic [15:0] mn8, mx8;
  logic [7:0]  mni8, mxi8, cnt8;
  logic        r2, v2, nan2, alln2, ovf2;
  logic [15:0] mn2, mx2;
  logic [1:0]  mni2, mxi2, cnt2;

  always #5 clk = ~clk;

  fp16_minmax_scan #(.IDX_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(r8), .out_valid(v8), .out_ready(out_ready),
    .out_min(mn8), .out_max(mx8), .out_min_idx(mni8), .out_max_idx(mxi8),
    .out_count(cnt8), .out_nan_seen(nan8), .out_all_nan(alln8), .out_ovf(ovf8));

  fp16_minmax_scan #(.IDX_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(r2), .out_valid(v2), .out_ready(out_ready),
    .out_min(mn2), .out_max(mx2), .out_min_idx(mni2), .out_max_idx(mxi2),
    .out_count(cnt2), .out_nan_seen(nan2), .out_all_nan(alln2), .out_ovf(ovf2));

  typedef struct {
    logic [15:0] mn, mx;
    int          mni, mxi, cnt;
    bit          nan, alln, ovf;
  } exp_t;

  exp_t        q8[$], q2[$];
  logic [15:0] burst[$];
  int          checks = 0, failures = 0;

  // out_ready owner: 0 = always ready, 1 = stalled, 2 = random.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      1:       out_ready = 1'b0;
      2:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b1;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic bit nan_of(input logic [15:0] h);
    return (((h >> 10) & 16'h1F) == 16'h1F) && ((h & 16'h3FF) != 0);
  endfunction

  // Numeric value of a non-NaN fp16; infinities become huge finite reals.
  function automatic real fp_val(input logic [15:0] h);
    int  e = int'((h >> 10) & 16'h1F);
    int  m = int'(h & 16'h3FF);
    real v;
    if (e == 31) begin
      v = 1.0e30;
    end else begin
      v = (e == 0) ? real'(m) : real'(m + 1024);
      if (e == 0) e = 1;
      for (int k = e; k < 25; k++) v = v / 2.0;
      for (int k = 25; k < e; k++) v = v * 2.0;
    end
    return (h >= 16'h8000) ? -v : v;
  endfunction

  function automatic exp_t model(input int w);
    exp_t e;
    int   cap = (1 << w) - 1;
    bit   have = 0;
    real  v, vmn = 0.0, vmx = 0.0;
    e.mn = 16'h7E00; e.mx = 16'h7E00; e.mni = 0; e.mxi = 0; e.nan = 0;
    for (int i = 0; i < burst.size(); i++) begin
      int pos;
      pos = (i < cap) ? i : cap;
      if (nan_of(burst[i])) begin
        e.nan = 1;
        continue;
      end
      v = fp_val(burst[i]);
      if (!have || v < vmn) begin vmn = v; e.mn = burst[i]; e.mni = pos; end
      if (!have || v > vmx) begin vmx = v; e.mx = burst[i]; e.mxi = pos; end
      have = 1;
    end
    e.cnt  = (burst.size() < cap) ? burst.size() : cap;
    e.ovf  = burst.size() > cap;
    e.alln = !have;
    return e;
  endfunction

  task automatic cmp(input string t, input exp_t e, input logic [15:0] mn, input logic [15:0] mx,
                     input logic [31:0] mni, input logic [31:0] mxi, input logic [31:0] cnt,
                     input logic nan, input logic alln, input logic ovf);
    chk({t, "_min"}, 32'(mn), 32'(e.mn));
    chk({t, "_max"}, 32'(mx), 32'(e.mx));
    chk({t, "_min_idx"}, mni, e.mni);
    chk({t, "_max_idx"}, mxi, e.mxi);
    chk({t, "_count"}, cnt, e.cnt);
    chk({t, "_nan_seen"}, 32'(nan), 32'(e.nan));
    chk({t, "_all_nan"}, 32'(alln), 32'(e.alln));
    chk({t, "_ovf"}, 32'(ovf), 32'(e.ovf));
  endtask

  // Monitors: a summary transfers on the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n && v8 === 1'b1 && out_ready === 1'b1) begin
      if (q8.size() == 0) begin
        checks++; failures++;
        $display("FAIL w8_unexpected_summary actual=%0h expected=none", mn8);
      end else begin
        cmp("w8", q8.pop_front(), mn8, mx8, 32'(mni8), 32'(mxi8), 32'(cnt8), nan8, alln8, ovf8);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && v2 === 1'b1 && out_ready === 1'b1) begin
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL w2_unexpected_summary actual=%0h expected=none", mn2);
      end else begin
        cmp("w2", q2.pop_front(), mn2, mx2, 32'(mni2), 32'(mxi2), 32'(cnt2), nan2, alln2, ovf2);
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic l);
    bit acc = 0;
    int g = 0;
    in_data = d; in_last = l; in_valid = 1'b1;
    while (!acc && g < 500) begin
      @(negedge clk);
      acc = (r8 === 1'b1);
      if (acc) chk("in_ready_w2", 32'(r2), 1);
      @(posedge clk); #1;
      g++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!acc) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=%0h expected=accepted", d);
    end else begin
      burst.push_back(d);
      if (l) begin
        q8.push_back(model(8));
        q2.push_back(model(2));
        burst.delete();
        chk("lat_out_valid", 32'(v8), 1);
        chk("lat_in_ready", 32'(r8), 0);
        chk("lat_out_valid_w2", 32'(v2), 1);
      end
    end
  endtask

  task automatic send_burst(input logic [15:0] v[$]);
    for (int i = 0; i < v.size(); i++) send(v[i], i == v.size() - 1);
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((q8.size() != 0 || q2.size() != 0) && g < 200) begin
      @(posedge clk); g++;
    end
    chk("drain", q8.size() + q2.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] rnd_val();
    logic [15:0] r = 16'($urandom);
    case ($urandom_range(0, 7))
      0:       return r & 16'h8000;
      1:       return (r & 16'h8000) | 16'h7C00;
      2:       return r | 16'h7C01;
      3:       return r & 16'h83FF;
      4:       return (r[0]) ? 16'h3C00 : 16'hBC00;
      default: return r;
    endcase
  endfunction

  initial begin
    logic [15:0] lb[$];
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(r8), 0);
    chk("rst_out_valid", 32'(v8), 0);
    chk("rst_out_min", 32'(mn8), 0);
    chk("rst_out_max", 32'(mx8), 0);
    chk("rst_idx", 32'({mni8, mxi8}), 0);
    chk("rst_count", 32'(cnt8), 0);
    chk("rst_flags", 32'({nan8, alln8, ovf8}), 0);
    chk("rst_w2", 32'({r2, v2, cnt2, ovf2}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_before_edge", 32'(r8), 0);
    @(posedge clk); #1;
    chk("in_ready_rise", 32'(r8), 1);

    send_burst('{16'h543E, 16'h5092, 16'h717C, 16'hDD43});
    send_burst('{16'h0DD8});
    send_burst('{16'h7C00, 16'hD8EA});
    send_burst('{16'h0000, 16'h8000, 16'h0000});
    send_burst('{16'h7C01, 16'hD8EA, 16'hFE00});
    send_burst('{16'h7E00});
    send_burst('{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h3800});
    wait_drain();

    // Backpressure: summary held, a pending element must not be taken.
    rdy_mode = 1;
    send_burst('{16'h3C00, 16'hBC00});
    in_valid = 1'b1; in_last = 1'b1; in_data = 16'h4000;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(r8), 0);
      chk("bp_out_valid", 32'(v8), 1);
      chk("bp_out_min", 32'(mn8), 32'(q8[0].mn));
      chk("bp_out_max", 32'(mx8), 32'(q8[0].mx));
      chk("bp_count", 32'(cnt8), 32'(q8[0].cnt));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    rdy_mode = 0;
    @(posedge clk); #1;
    rdy_mode = 1;
    chk("bp_release_out_valid", 32'(v8), 0);
    chk("bp_release_in_ready", 32'(r8), 1);
    chk("bp_drained", q8.size() + q2.size(), 0);
    rdy_mode = 0;
    @(posedge clk); #1;

    // Reset in the middle of a burst discards it.
    send(16'h4400, 1'b0);
    send(16'hC400, 1'b0);
    rst_n = 1'b0;
    burst.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(v8), 0);
    chk("midrst_in_ready", 32'(r8), 0);
    chk("midrst_count", 32'({cnt8, cnt2}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_burst('{16'h5092});
    wait_drain();

    // Randomized bursts with idle gaps and random downstream stalls.
    rdy_mode = 2;
    for (int b = 0; b < 40; b++) begin
      int n = $urandom_range(1, 7);
      if ($urandom_range(0, 1) != 0) begin
        in_last = 1'(($urandom_range(0, 1)));
        @(posedge clk); #1;
        in_last = 1'b0;
      end
      for (int i = 0; i < n; i++) send(rnd_val(), i == n - 1);
    end
    lb.delete();
    for (int i = 0; i < 260; i++) lb.push_back(rnd_val());
    send_burst(lb);
    rdy_mode = 0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
